adc_burst_detector: RTL

Burst-level detection stage downstream of the ADC sample path in `dsp_top`. It consumes ADC samples already retimed onto the 100 MHz system clock and frames them into bursts, which arrive as roughly 1 µs active windows separated by long idle gaps. For each burst it tracks peak magnitude, length, threshold hits and overflow. At burst end it emits a one-cycle `DETECTED` decision together with a registered burst summary.

---
 rtl/adc_burst_detector.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adc_burst_detector.sv
// Frames retimed ADC samples into bursts and reports per-burst peak magnitude,
// length, threshold hits and overflow, with a one-cycle detection decision.
module adc_burst_detector #(
  parameter int DATA_W     = 12,
  parameter int GAP_CYCLES = 8,
  parameter int MIN_HITS   = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK_100MHz,
  input  logic              SRESET_n,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE_DATA,
  input  logic              SAMPLE_OF,
  input  logic [DATA_W-1:0] DETECTION_THRESHOLD,
  output logic              DETECTED,
  output logic              BURST_DONE,
  output logic [DATA_W-1:0] BURST_PEAK,
  output logic [CNT_W-1:0]  BURST_LEN,
  output logic [CNT_W-1:0]  BURST_HITS,
  output logic              BURST_OF,
  output logic              BUSY,
  output logic [1:0]        o_dbg_state
);

  // Handshake: SAMPLE_VALID qualifies SAMPLE_DATA/SAMPLE_OF in the same cycle.
  // There is no ready; every valid sample is consumed on the clock edge it is
  // presented (once the post-reset run flag is set).

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_REPORT} state_t;

  localparam logic [DATA_W-1:0] HALF       = DATA_W'(1) << (DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  MIN_HITS_C = CNT_W'(MIN_HITS);
  localparam logic [7:0]        GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_run;
  logic [DATA_W-1:0]   r_thr;
  logic [DATA_W-1:0]   r_peak;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_hits;
  logic                r_of;
  logic [7:0]          r_gap_cnt;
  logic [7:0]          w_gap_nxt;
  logic                w_valid;
  logic                w_open;
  logic                w_accum;
  logic                w_report;
  logic                w_hit;
  logic [DATA_W-1:0]   w_mag;
  logic [DATA_W-1:0]   w_thr;
  logic [CNT_W-1:0]    w_len_inc;
  logic [CNT_W-1:0]    w_hits_inc;

  // Synchronous release: samples are taken from the second edge after reset rises.
  always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
    if (!SRESET_n) r_run <= 1'b0;
    else           r_run <= 1'b1;
  end

  assign w_valid = SAMPLE_VALID & r_run;

  always_comb begin
    if (SAMPLE_DATA[DATA_W-1]) w_mag = SAMPLE_DATA - HALF;
    else                       w_mag = HALF - SAMPLE_DATA;
  end

  // The opening sample is judged against the live threshold; later ones use the latch.
  assign w_thr      = (r_state == S_ACTIVE || r_state == S_GAP) ? r_thr : DETECTION_THRESHOLD;
  assign w_hit      = (w_mag > w_thr) | SAMPLE_OF;
  assign w_len_inc  = (r_len == CNT_MAX) ? r_len : r_len + 1'b1;
  assign w_hits_inc = (r_hits == CNT_MAX) ? r_hits : r_hits + 1'b1;

  always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
    if (!SRESET_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_open      = 1'b0;
    w_accum     = 1'b0;
    w_report    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_open      = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_valid) begin
          w_accum = 1'b1;
        end else if (GAP_CYCLES == 1) begin
          w_report    = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_REPORT;
        end else begin
          w_gap_nxt   = 8'd1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_valid) begin
          w_accum     = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_ACTIVE;
        end else if (r_gap_cnt == GAP_LAST) begin
          // This idle cycle completes the gap; the report registers load now.
          w_report    = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_REPORT;
        end else begin
          w_gap_nxt = r_gap_cnt + 8'd1;
        end
      end
      S_REPORT: begin
        if (w_valid) begin
          w_open      = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_ACTIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
    if (!SRESET_n) begin
      r_thr     <= '0;
      r_peak    <= '0;
      r_len     <= '0;
      r_hits    <= '0;
      r_of      <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= w_gap_nxt;
      if (w_open) begin
        r_thr  <= DETECTION_THRESHOLD;
        r_peak <= w_mag;
        r_len  <= CNT_W'(1);
        r_hits <= w_hit ? CNT_W'(1) : '0;
        r_of   <= SAMPLE_OF;
      end else if (w_accum) begin
        r_len <= w_len_inc;
        if (w_hit)          r_hits <= w_hits_inc;
        if (w_mag > r_peak) r_peak <= w_mag;
        if (SAMPLE_OF)      r_of   <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100MHz or negedge SRESET_n) begin
    if (!SRESET_n) begin
      DETECTED   <= 1'b0;
      BURST_DONE <= 1'b0;
      BURST_PEAK <= '0;
      BURST_LEN  <= '0;
      BURST_HITS <= '0;
      BURST_OF   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      BURST_DONE <= w_report;
      DETECTED   <= w_report && (r_hits >= MIN_HITS_C);
      BUSY       <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_GAP);
      if (w_report) begin
        BURST_PEAK <= r_peak;
        BURST_LEN  <= r_len;
        BURST_HITS <= r_hits;
        BURST_OF   <= r_of;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule
